// File: rtl/barrel_pkg.sv
// Shared constants and types for the shared barrel rotator arbiter.
// Optional grant statistics are enabled with ROT_STATS_EN.
package barrel_pkg;

  localparam int DATA_W = 8;
  localparam int MAG_W  = 3;
  localparam int STAT_W = 16;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/barrel_rot8.sv
// Combinational 8-bit rotator.
// dir=0 rotates right, dir=1 rotates left, by mag positions.
module barrel_rot8
  import barrel_pkg::*;
(
  input  logic              dir,
  input  logic [MAG_W-1:0]  mag,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [MAG_W-1:0] idx;

  // Each output bit picks its source bit; index math wraps mod 8.
  always_comb begin
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (dir == DIR_LEFT) begin
        idx = MAG_W'(k) - mag;
      end else begin
        idx = MAG_W'(k) + mag;
      end
      data_o[k] = data_i[idx];
    end
  end

endmodule

// File: rtl/barrel_rot_arbiter.sv
// Round-robin arbiter sharing one barrel_rot8 among NREQ requesters.
// ROT_STATS_EN adds per-requester saturating grant counters.
module barrel_rot_arbiter
  import barrel_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_dir,
  input  logic [MAG_W*NREQ-1:0]  req_mag,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
`ifdef ROT_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [STAT_W*NREQ-1:0] stat_cnt
`endif
);

  rsp_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic              found;
  logic [IDW-1:0]    win;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    cand;
  logic              slot_free;
  logic              grant;
  logic              sel_dir;
  logic [MAG_W-1:0]  sel_mag;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rot_out;

  // Search for the first valid requester starting at the RR pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Route the winner's operands to the shared rotator.
  always_comb begin
    sel_dir  = req_dir[win];
    sel_mag  = req_mag[win*MAG_W +: MAG_W];
    sel_data = req_data[win*DATA_W +: DATA_W];
  end

  barrel_rot8 u_rot (
    .dir    (sel_dir),
    .mag    (sel_mag),
    .data_i (sel_data),
    .data_o (rot_out)
  );

  // Handshake: grant only when the result slot is free or draining.
  always_comb begin
    slot_free = (state_q == ST_EMPTY) | rsp_ready;
    grant     = found & slot_free;
    req_ready = '0;
    if (grant && rst_n) begin
      req_ready = NREQ'(1) << win;
    end
  end

  // Next state for pointer, result register and occupancy.
  always_comb begin
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    state_d    = state_q;
    if (grant) begin
      ptr_d      = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      rsp_data_d = rot_out;
      rsp_id_d   = win;
    end
    unique case (state_q)
      ST_EMPTY: begin
        if (grant) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (rsp_ready) state_d = grant ? ST_FULL : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Register arbiter and result state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid | (|req_valid);

`ifdef ROT_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];
  logic [STAT_W-1:0] cnt_d [NREQ];

  // Count grants per requester; clear wins over a same-cycle grant.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (req_ready[i]) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  // Register the grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_barrel_rot_arbiter.sv
// Scoreboard bench for barrel_rot_arbiter (NREQ=4).
// Stats scenario runs only when ROT_STATS_EN is defined.
module tb_barrel_rot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_dir;
  logic [11:0] req_mag;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef ROT_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_cnt;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_pass;
  int   n_total;

  logic [7:0] fd [4];
  logic       fdir [4];
  int         fmag [4];

  barrel_rot_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dir   (req_dir),
    .req_mag   (req_mag),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ROT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rot(logic [7:0] d, logic dir, int m);
    logic [15:0] w;
    w = {d, d};
    if (dir) begin
      w = w << m;
      return w[15:8];
    end
    w = w >> m;
    return w[7:0];
  endfunction

  task automatic set_req(int i, logic dir, int mag, logic [7:0] d);
    req_dir[i]        = dir;
    req_mag[i*3 +: 3] = 3'(mag);
    req_data[i*8 +: 8] = d;
  endtask

  // Advance one cycle, retire drained entries, compare held result.
  task automatic cycle();
    logic hs;
    hs = rsp_valid & rsp_ready;
    @(posedge clk);
    if (hs && sbq.size() > 0) void'(sbq.pop_front());
    @(negedge clk);
    if (rsp_valid) begin
      n_total++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected: id=%0d data=%h, none expected",
                 rsp_id, rsp_data);
      end else if (rsp_id !== sbq[0].id || rsp_data !== sbq[0].data) begin
        $display("FAIL sb_rsp: id=%0d data=%h, want id=%0d data=%h",
                 rsp_id, rsp_data, sbq[0].id, sbq[0].data);
      end else n_pass++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    @(negedge clk);
    n_total++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h0
        || rsp_id !== 2'd0) begin
      $display("FAIL reset_state: rdy=%b v=%b d=%h id=%0d, want 0",
               req_ready, rsp_valid, rsp_data, rsp_id);
    end else n_pass++;
    req_valid = 4'b0;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 1, 8'h81);
    req_valid = 4'b0001;
    #1;
    n_total++;
    if (req_ready !== 4'b0001 || busy !== 1'b1)
      $display("FAIL single_ready: rdy=%b busy=%b, want 0001 1", req_ready, busy);
    else n_pass++;
    sbq.push_back('{2'd0, 8'hC0});
    cycle();
    req_valid = 4'b0;
    n_total++;
    if (rsp_valid !== 1'b1) $display("FAIL single_latency: rsp_valid=%b want 1", rsp_valid);
    else n_pass++;
    cycle();
    n_total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_drain: v=%b busy=%b want 0 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_left();
    set_req(2, 1'b1, 3, 8'h81);
    req_valid = 4'b0100;
    #1;
    n_total++;
    if (req_ready !== 4'b0100) $display("FAIL left_ready: got %b want 0100", req_ready);
    else n_pass++;
    sbq.push_back('{2'd2, 8'h0C});
    cycle();
    set_req(2, 1'b0, 0, 8'h5A);
    #1;
    sbq.push_back('{2'd2, 8'h5A});
    cycle();
    set_req(2, 1'b1, 0, 8'h5A);
    #1;
    sbq.push_back('{2'd2, 8'h5A});
    cycle();
    req_valid = 4'b0;
    cycle();
  endtask

  task automatic test_fairness();
    int e;
    do_reset();
    fd   = '{8'h81, 8'h3C, 8'hA5, 8'h0F};
    fdir = '{1'b0, 1'b1, 1'b0, 1'b1};
    fmag = '{1, 2, 5, 7};
    for (int i = 0; i < 4; i++) set_req(i, fdir[i], fmag[i], fd[i]);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      e = n % 4;
      #1;
      n_total++;
      if (req_ready !== (4'b0001 << e))
        $display("FAIL fair_grant%0d: got %b want %b", n, req_ready, 4'b0001 << e);
      else n_pass++;
      sbq.push_back('{2'(e), rot(fd[e], fdir[e], fmag[e])});
      cycle();
    end
    req_valid = 4'b0;
    cycle();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL fair_drain: v=%b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0001;
    #1;
    sbq.push_back('{2'd0, rot(fd[0], fdir[0], fmag[0])});
    cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_total++;
      if (req_ready !== 4'b0 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: rdy=%b busy=%b want 0000 1", n, req_ready, busy);
      else n_pass++;
      cycle();
    end
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release: got %b want 0010", req_ready);
    else n_pass++;
    sbq.push_back('{2'd1, rot(fd[1], fdir[1], fmag[1])});
    cycle();
    req_valid = 4'b0;
    cycle();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010;
    #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL mid_pre: got %b want 0010", req_ready);
    else n_pass++;
    sbq.push_back('{2'd1, rot(fd[1], fdir[1], fmag[1])});
    cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h0 || rsp_id !== 2'd0)
      $display("FAIL mid_async: v=%b d=%h id=%0d want 0 00 0",
               rsp_valid, rsp_data, rsp_id);
    else n_pass++;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL mid_ptr: got %b want 0010", req_ready);
    else n_pass++;
    sbq.push_back('{2'd1, rot(fd[1], fdir[1], fmag[1])});
    cycle();
    req_valid = 4'b0;
    cycle();
  endtask

`ifdef ROT_STATS_EN
  task automatic test_stats();
    logic [7:0] e3;
    do_reset();
    e3 = rot(fd[3], fdir[3], fmag[3]);
    n_total++;
    if (stat_cnt !== 64'h0) $display("FAIL stat_reset: got %h want 0", stat_cnt);
    else n_pass++;
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    for (int n = 0; n < 10; n++) begin
      #1;
      sbq.push_back('{2'd3, e3});
      cycle();
    end
    n_total++;
    if (stat_cnt[63:48] !== 16'd10) $display("FAIL stat_ten: got %0d want 10", stat_cnt[63:48]);
    else n_pass++;
    stat_clr = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b1000) $display("FAIL stat_clr_grant: got %b want 1000", req_ready);
    else n_pass++;
    sbq.push_back('{2'd3, e3});
    cycle();
    stat_clr = 1'b0;
    n_total++;
    if (stat_cnt[63:48] !== 16'd0) $display("FAIL stat_clr: got %0d want 0", stat_cnt[63:48]);
    else n_pass++;
    for (int n = 0; n < 65535; n++) begin
      #1;
      sbq.push_back('{2'd3, e3});
      cycle();
    end
    n_total++;
    if (stat_cnt[63:48] !== 16'hFFFF) $display("FAIL stat_max: got %h want ffff", stat_cnt[63:48]);
    else n_pass++;
    #1;
    sbq.push_back('{2'd3, e3});
    cycle();
    n_total++;
    if (stat_cnt[63:48] !== 16'hFFFF || stat_cnt[47:0] !== 48'h0)
      $display("FAIL stat_sat: got %h want ffff000000000000", stat_cnt);
    else n_pass++;
    req_valid = 4'b0;
    cycle();
  endtask
`endif

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_dir   = 4'b0;
    req_mag   = 12'h0;
    req_data  = 32'h0;
    rsp_ready = 1'b0;
`ifdef ROT_STATS_EN
    stat_clr  = 1'b0;
`endif
    test_reset();
    test_single();
    test_left();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef ROT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
